// File: rtl/enc_pkg.sv
// enc_pkg: operation codes, RV32 opcode/funct constants and loader states for instr_encoder.
package enc_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_XOR  = 4'd3,
    OP_SLL  = 4'd4,
    OP_ADDI = 4'd5,
    OP_ANDI = 4'd6,
    OP_LW   = 4'd7,
    OP_SW   = 4'd8,
    OP_LUI  = 4'd9
  } op_e;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational RV32 encoder for the supported op subset.
// Optional immediate range checking is enabled by ENC_RANGE_CHECK_EN.
module instr_field_pack
  import enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  logic imm12_ok, imm20_ok;
  logic [2:0] f3;
  logic [6:0] f7;
`ifdef ENC_RANGE_CHECK_EN
  assign imm12_ok = &imm[31:11] | ~|imm[31:11];
  assign imm20_ok = ~|imm[31:20];
`else
  logic unused_imm;
  assign unused_imm = ^imm[31:20];
  assign imm12_ok = 1'b1;
  assign imm20_ok = 1'b1;
`endif
  assign f3 = (op == OP_AND || op == OP_ANDI) ? F3_AND :
              op == OP_XOR ? F3_XOR :
              op == OP_SLL ? F3_SLL :
              op == OP_LW  ? F3_LW  : F3_ADD;
  assign f7 = op == OP_SUB ? F7_SUB : F7_BASE;
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL: begin
        word  = {f7, rs2, rs1, f3, rd, OPC_R};
        legal = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_LW: begin
        word  = {imm[11:0], rs1, f3, rd, op == OP_LW ? OPC_LOAD : OPC_I};
        legal = imm12_ok;
      end
      OP_SW: begin
        word  = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_S};
        legal = imm12_ok;
      end
      OP_LUI: begin
        word  = {imm[19:0], rd, OPC_LUI};
        legal = imm20_ok;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: program loader writing encoded RV32 words to consecutive imem addresses.
// Define ENC_RANGE_CHECK_EN to drop ops whose immediates do not fit their fields.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_e state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic full, legal, acc, wr;
  logic [31:0] word;
  instr_field_pack u_pack (
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .word(word), .legal(legal)
  );
  assign busy     = state == LOAD;
  assign done     = state == DONE;
  assign in_ready = busy && !full;
  // a restart discards any op offered in the same cycle
  assign acc = in_valid && in_ready && !start;
  assign wr  = acc && legal;
  always_comb
    state_d = start ? LOAD :
              (busy && (stop || (wr && ptr == LAST))) ? DONE : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      full       <= 1'b0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state   <= state_d;
      imem_we <= wr;
      if (wr) begin
        imem_addr  <= ptr;
        imem_wdata <= word;
      end
      if (start) begin
        ptr   <= BASE;
        full  <= 1'b0;
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (wr) begin
          count <= count + (ADDR_W+1)'(1);
          full  <= ptr == LAST;
          if (ptr != LAST) ptr <= ptr + ADDR_W'(1);
        end
        if (acc && !legal) err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a behavioural model.
module tb_instr_encoder;
  logic clk = 0, rst = 1;
  logic start = 0, stop = 0, in_valid = 0;
  logic [3:0] op = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] imm = 0;
  logic in_ready, imem_we, busy, done, err;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0] count;
  logic s_start = 0, s_stop = 0, s_valid = 0;
  logic s_ready, s_we, s_busy, s_done, s_err;
  logic [1:0] s_addr;
  logic [31:0] s_wdata;
  logic [2:0] s_count;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .in_valid(s_valid), .in_ready(s_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .imem_we(s_we), .imem_addr(s_addr),
    .imem_wdata(s_wdata), .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {legal, word} from the instruction set definition
  function automatic logic [32:0] enc(input int o, input int d, input int a, input int b,
                                      input logic [31:0] i);
    logic [31:0] w, f3;
    int s;
    bit fit12, fit20;
    s = i;
    fit12 = 1;
    fit20 = 1;
`ifdef ENC_RANGE_CHECK_EN
    fit12 = s >= -2048 && s <= 2047;
    fit20 = i < 32'h100000;
`endif
    f3 = (o == 2 || o == 6) ? 7 : o == 3 ? 4 : o == 4 ? 1 : o == 7 ? 2 : 0;
    case (o)
      0, 1, 2, 3, 4:
        return {1'b1, (o == 1 ? 32'h4000_0000 : 32'h0) + b * 2**20 + a * 2**15 + f3 * 2**12 + d * 2**7 + 32'h33};
      5, 6, 7: begin
        w = (i & 32'hfff) * 2**20 + a * 2**15 + f3 * 2**12 + d * 2**7 + (o == 7 ? 32'h03 : 32'h13);
        return {fit12, w};
      end
      8: begin
        w = ((i >> 5) & 32'h7f) * 2**25 + b * 2**20 + a * 2**15 + 2 * 2**12 + (i & 32'h1f) * 2**7 + 32'h23;
        return {fit12, w};
      end
      9: return {fit20, (i & 32'hfffff) * 2**12 + d * 2**7 + 32'h37};
      default: return 33'h0;
    endcase
  endfunction

  // model of the 256-word loader: 0 idle, 1 loading, 2 done
  int m_state, m_ptr, m_cnt;
  bit m_err, m_full, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [32:0] m_enc;
  bit m_acc;
  assign m_enc = enc(op, rd, rs1, rs2, imm);
  assign m_acc = in_valid && m_state == 1 && !m_full && !start;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_ptr <= 0; m_cnt <= 0; m_err <= 0; m_full <= 0;
      m_we <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (start) begin
      m_state <= 1; m_ptr <= 0; m_cnt <= 0; m_err <= 0; m_full <= 0; m_we <= 0;
    end else begin
      m_we <= m_acc && m_enc[32];
      if (m_acc && m_enc[32]) begin
        m_addr  <= m_ptr;
        m_wdata <= m_enc[31:0];
        m_cnt   <= m_cnt + 1;
        if (m_ptr == 255) m_full <= 1;
        else m_ptr <= m_ptr + 1;
      end
      if (m_acc && !m_enc[32]) m_err <= 1;
      if (m_state == 1 && (stop || (m_acc && m_enc[32] && m_ptr == 255))) m_state <= 2;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("we", imem_we, m_we);
      if (m_we) begin
        chk("addr", imem_addr, m_addr);
        chk("wdata", imem_wdata, m_wdata);
      end
      chk("busy", busy, m_state == 1);
      chk("done", done, m_state == 2);
      chk("err", err, m_err);
      chk("count", count, m_cnt);
      chk("in_ready", in_ready, m_state == 1 && !m_full);
    end
  end

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic put(input int o, input int d, input int a, input int b, input logic [31:0] i);
    in_valid = 1;
    op = 4'(o); rd = 5'(d); rs1 = 5'(a); rs2 = 5'(b); imm = i;
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_we", imem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    rst = 0;
    // start with a valid op while idle: no transfer
    start = 1; in_valid = 1; op = 0; rd = 3; rs1 = 1; rs2 = 2;
    @(negedge clk);
    start = 0; in_valid = 0;
    chk("idle_start_we", imem_we, 0);
    chk("idle_start_busy", busy, 1);
    put(0, 3, 1, 2, 0);
    chk("add_we", imem_we, 1);
    chk("add_addr", imem_addr, 0);
    chk("add_word", imem_wdata, 32'h002081B3);
    pulse_start();
    put(1, 5, 6, 7, 0);
    chk("sub_addr", imem_addr, 0);
    chk("sub_word", imem_wdata, 32'h407302B3);
    put(9, 1, 0, 0, 32'h12345);
    chk("lui_addr", imem_addr, 1);
    chk("lui_word", imem_wdata, 32'h123450B7);
    chk("lui_count", count, 2);
    pulse_start();
    put(8, 0, 8, 2, -32'sd4);
    chk("sw_word", imem_wdata, 32'hFE242E23);
    put(7, 4, 2, 0, 8);
    chk("lw_addr", imem_addr, 1);
    chk("lw_word", imem_wdata, 32'h00812203);
    pulse_start();
    put(0, 1, 1, 1, 0);
    put(12, 1, 1, 1, 0);
    chk("illegal_we", imem_we, 0);
    chk("illegal_err", err, 1);
    chk("illegal_count", count, 1);
    put(2, 1, 1, 1, 0);
    chk("after_illegal_addr", imem_addr, 1);
    chk("after_illegal_err", err, 1);
    pulse_start();
    chk("start_clears_err", err, 0);
    put(5, 1, 0, 0, 2048);
`ifdef ENC_RANGE_CHECK_EN
    chk("addi2048_we", imem_we, 0);
    chk("addi2048_err", err, 1);
`else
    chk("addi2048_we", imem_we, 1);
    chk("addi2048_word", imem_wdata, 32'h80000093);
`endif
    pulse_start();
    stop = 1;
    put(3, 2, 3, 4, 0);
    stop = 0;
    chk("stop_we", imem_we, 1);
    chk("stop_done", done, 1);
    put(3, 2, 3, 4, 0);
    chk("after_done_we", imem_we, 0);
    chk("after_done_ready", in_ready, 0);
    // fill all 256 words
    pulse_start();
    in_valid = 1; op = 5; rd = 7; rs1 = 9; imm = 32'h7ff;
    repeat (258) @(negedge clk);
    in_valid = 0;
    chk("fill_done", done, 1);
    chk("fill_count", count, 256);
    chk("fill_ready", in_ready, 0);
    // ADDR_W=2 instance: five back-to-back ops, four writes
    s_start = 1; @(negedge clk); s_start = 0;
    s_valid = 1; op = 0; rd = 1; rs1 = 2; rs2 = 3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("small_we", s_we, 1);
      chk("small_addr", s_addr, k);
    end
    chk("small_done", s_done, 1);
    chk("small_ready", s_ready, 0);
    @(negedge clk);
    s_valid = 0;
    chk("small_fifth_we", s_we, 0);
    chk("small_count", s_count, 4);
    // randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      start = $urandom % 40 == 0;
      stop = !start && $urandom % 30 == 0;
      in_valid = !start && $urandom % 10 < 7;
      op = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      imm = ($urandom % 2) ? 32'($urandom_range(0, 4095)) - 32'd2048 : $urandom;
      if (c == 1500) begin
        #3 rst = 1;
        #1;
        chk("async_rst_we", imem_we, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_count", count, 0);
        @(negedge clk);
        rst = 0;
      end else begin
        @(negedge clk);
      end
    end
    start = 0; stop = 0; in_valid = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
